// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM with 1-cycle read latency, UART TX FIFO / RX port,
// free-running cycle counter with coherent snapshot, and sticky program-stop flag.
module mem_io_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int TXQ_DEPTH_LOG = 4,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        tx_overflow,
    output logic        program_stop
);
    localparam int                   DEPTH    = 1 << TXQ_DEPTH_LOG;
    localparam logic [17:0]          IO_RX    = 18'h30000;
    localparam logic [17:0]          IO_CNT   = 18'h30004;
    localparam logic [TXQ_DEPTH_LOG:0] DEPTH_C  = (TXQ_DEPTH_LOG+1)'(DEPTH);
    localparam logic [TXQ_DEPTH_LOG:0] MARGIN_C = (TXQ_DEPTH_LOG+1)'(FULL_MARGIN);

    logic [7:0]              r_ram [0:(1<<RAM_ADDR_W)-1];
    logic [7:0]              r_ram_q;
    logic                    r_rd_ram;
    logic [7:0]              r_io_q;
    logic                    r_prev_rx;
    logic [31:0]             r_counter;
    logic [31:0]             r_snapshot;
    logic                    r_stop;
    logic                    r_overflow;
    logic                    r_near_full;
    logic [7:0]              r_txq [0:DEPTH-1];
    logic [TXQ_DEPTH_LOG-1:0] r_wr_ptr;
    logic [TXQ_DEPTH_LOG-1:0] r_rd_ptr;
    logic [TXQ_DEPTH_LOG:0]   r_count;

    logic                    w_io;
    logic                    w_rx_rd;
    logic                    w_cnt_rd;
    logic                    w_cnt_wr;
    logic [RAM_ADDR_W-1:0]   w_ram_addr;
    logic [7:0]              w_io_rdata;
    logic                    w_push_req;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic [TXQ_DEPTH_LOG:0]   w_count_nxt;
    logic                    w_unused_addr;

    assign w_io          = (mem_a[17:16] == 2'b11);
    assign w_ram_addr    = mem_a[RAM_ADDR_W-1:0];
    assign w_rx_rd       = !mem_wr && (mem_a[17:0] == IO_RX);
    assign w_cnt_rd      = !mem_wr && (mem_a[17:0] == IO_CNT);
    assign w_cnt_wr      = mem_wr && (mem_a[17:0] == IO_CNT);
    assign w_unused_addr = ^mem_a[31:18];

    // RAM contents survive reset; only the write strobe is qualified by it.
    always_ff @(posedge clk_in) begin
        if (!rst_in && mem_wr && !w_io)
            r_ram[w_ram_addr] <= mem_dout;
        r_ram_q <= r_ram[w_ram_addr];
    end

    // Byte 0 comes from the live counter because the snapshot loads on this same edge.
    always_comb begin
        w_io_rdata = 8'h00;
        if (mem_a[17:0] == IO_RX) begin
            w_io_rdata = rx_valid ? rx_data : 8'h00;
        end else if (mem_a[17:2] == IO_CNT[17:2]) begin
            case (mem_a[1:0])
                2'd0:    w_io_rdata = r_counter[7:0];
                2'd1:    w_io_rdata = r_snapshot[15:8];
                2'd2:    w_io_rdata = r_snapshot[23:16];
                default: w_io_rdata = r_snapshot[31:24];
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_ram   <= 1'b0;
            r_io_q     <= 8'h00;
            r_prev_rx  <= 1'b0;
            r_counter  <= 32'd0;
            r_snapshot <= 32'd0;
            r_stop     <= 1'b0;
        end else begin
            r_counter <= r_counter + 32'd1;
            r_rd_ram  <= !mem_wr && !w_io;
            r_io_q    <= (!mem_wr && w_io) ? w_io_rdata : 8'h00;
            r_prev_rx <= w_rx_rd;
            if (w_cnt_rd)
                r_snapshot <= r_counter;
            if (w_cnt_wr)
                r_stop <= 1'b1;
        end
    end

    assign mem_din      = r_rd_ram ? r_ram_q : r_io_q;
    assign rx_pop       = !rst_in && w_rx_rd && rx_valid && !r_prev_rx;
    assign program_stop = r_stop;

    assign w_push_req  = mem_wr && (mem_a[17:0] == IO_RX) && (mem_dout != 8'h00);
    assign w_pop       = tx_valid && tx_ready;
    assign w_full      = (r_count == DEPTH_C);
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_count_nxt = r_count + {{TXQ_DEPTH_LOG{1'b0}}, w_push}
                                 - {{TXQ_DEPTH_LOG{1'b0}}, w_pop};

    always_ff @(posedge clk_in) begin
        if (!rst_in && w_push)
            r_txq[r_wr_ptr] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_near_full <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + TXQ_DEPTH_LOG'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + TXQ_DEPTH_LOG'(1);
            if (w_push_req && !w_push)
                r_overflow <= 1'b1;
            r_count     <= w_count_nxt;
            r_near_full <= ((DEPTH_C - w_count_nxt) <= MARGIN_C);
        end
    end

    assign tx_data        = r_txq[r_rd_ptr];
    assign tx_valid       = (r_count != '0);
    assign tx_overflow    = r_overflow;
    assign io_buffer_full = r_near_full;

endmodule
